// File: rtl/irq_stim_if.sv
// Bus between the interrupt stimulus generator and the bench that consumes it.
// The generator side is the master: it drives irq and the status counters.
interface irq_stim_if #(
   parameter int N_CH  = 6,
   parameter int CNT_W = 32
) ();
   logic             en;
   logic [N_CH-1:0]  ack;
   logic [N_CH-1:0]  irq;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] fire_total;
   logic             done;
   logic             timeout;

   modport master (
      input  en, ack,
      output irq, cycle_cnt, fire_total, done, timeout
   );

   modport slave (
      output en, ack,
      input  irq, cycle_cnt, fire_total, done, timeout
   );
endinterface

// File: rtl/irq_stim_gen.sv
// Interrupt stimulus generator: N_CH staggered channels (pulse or level mode),
// cycle counter, completion flag and sticky watchdog.
module irq_stim_ch #(
   parameter int CNT_W       = 32,
   parameter int K           = 0,
   parameter int FIRST_DELAY = 100,
   parameter int STAGGER     = 37,
   parameter int PERIOD      = 500,
   parameter int PULSE_W     = 4,
   parameter int LEVEL_MODE  = 0,
   parameter int MAX_FIRES   = 3
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_adv,
   input  logic i_freeze,
   input  logic i_ack,
   output logic o_irq,
   output logic o_fire,
   output logic o_stop
);
   typedef enum logic [1:0] {S_WAIT, S_ACTIVE, S_STOP} state_t;

   localparam logic [CNT_W-1:0] C_INIT   = CNT_W'(FIRST_DELAY + K*STAGGER);
   localparam logic [CNT_W-1:0] C_PERIOD = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0] C_PW     = CNT_W'(PULSE_W);
   localparam logic [CNT_W-1:0] C_MAXF   = CNT_W'(MAX_FIRES);
   localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt, r_wcnt, r_fcnt;
   logic             r_irq;
   logic             w_end, w_last;

   // Level mode ends on ack regardless of en; pulse mode ends when the width runs out.
   assign w_end  = (r_state == S_ACTIVE) && !i_freeze &&
                   ((LEVEL_MODE != 0) ? i_ack : (i_adv && r_wcnt == C_ONE));
   assign w_last = (MAX_FIRES != 0) && (r_fcnt == C_MAXF);
   assign o_fire = (r_state == S_WAIT) && i_adv && (r_cnt == C_ONE);
   assign o_stop = (r_state == S_STOP);
   assign o_irq  = r_irq;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_WAIT;
         r_cnt   <= C_INIT;
         r_wcnt  <= '0;
         r_fcnt  <= '0;
         r_irq   <= 1'b0;
      end else if (i_freeze) begin
         r_irq   <= 1'b0;
      end else begin
         case (r_state)
            S_WAIT: if (i_adv) begin
               if (r_cnt == C_ONE) begin
                  r_state <= S_ACTIVE;
                  r_irq   <= 1'b1;
                  r_wcnt  <= C_PW;
                  r_fcnt  <= (r_fcnt == '1) ? r_fcnt : r_fcnt + C_ONE;
               end else begin
                  r_cnt   <= r_cnt - C_ONE;
               end
            end
            S_ACTIVE: begin
               if (w_end) begin
                  r_irq   <= 1'b0;
                  r_state <= w_last ? S_STOP : S_WAIT;
                  r_cnt   <= C_PERIOD;
               end else if (i_adv && LEVEL_MODE == 0) begin
                  r_wcnt  <= r_wcnt - C_ONE;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

module irq_stim_gen #(
   parameter int N_CH        = 6,
   parameter int CNT_W       = 32,
   parameter int FIRST_DELAY = 100,
   parameter int STAGGER     = 37,
   parameter int PERIOD      = 500,
   parameter int PULSE_W     = 4,
   parameter int LEVEL_MODE  = 0,
   parameter int MAX_FIRES   = 3,
   parameter int MAX_CYCLES  = 100000
) (
   input  logic      i_clk,
   input  logic      i_reset,
   irq_stim_if.master bus
);
   logic [CNT_W-1:0] r_cycle, r_ftot;
   logic             r_done, r_timeout;
   logic [N_CH-1:0]  w_irq, w_fire, w_stop;
   logic             w_hit, w_freeze, w_adv;
   logic [CNT_W:0]   w_sum;

   // Watchdog trips on the edge that would bring cycle_cnt up to MAX_CYCLES.
   assign w_hit    = bus.en && !r_timeout && (MAX_CYCLES != 0) &&
                     (r_cycle == CNT_W'(MAX_CYCLES - 1));
   assign w_freeze = r_timeout | w_hit;
   assign w_adv    = bus.en & ~w_freeze;

   always_comb begin
      w_sum = {1'b0, r_ftot};
      for (int i = 0; i < N_CH; i++)
         w_sum = w_sum + {{CNT_W{1'b0}}, w_fire[i]};
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      irq_stim_ch #(
         .CNT_W(CNT_W), .K(g), .FIRST_DELAY(FIRST_DELAY), .STAGGER(STAGGER),
         .PERIOD(PERIOD), .PULSE_W(PULSE_W), .LEVEL_MODE(LEVEL_MODE),
         .MAX_FIRES(MAX_FIRES)
      ) u_ch (
         .i_clk(i_clk), .i_reset(i_reset), .i_adv(w_adv), .i_freeze(w_freeze),
         .i_ack(bus.ack[g]), .o_irq(w_irq[g]), .o_fire(w_fire[g]), .o_stop(w_stop[g])
      );
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cycle   <= '0;
         r_ftot    <= '0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         if (bus.en && !r_timeout && r_cycle != '1)
            r_cycle <= r_cycle + CNT_W'(1);
         if (w_hit)
            r_timeout <= 1'b1;
         r_ftot <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
         r_done <= &w_stop;
      end
   end

   assign bus.irq        = w_irq;
   assign bus.cycle_cnt  = r_cycle;
   assign bus.fire_total = r_ftot;
   assign bus.done       = r_done;
   assign bus.timeout    = r_timeout;
endmodule

// File: tb/tb_irq_stim_gen.sv
// Bench for irq_stim_gen: timeline table, hand-written corner sequences on four
// configurations, and a random-en run checked against a schedule-based model.
module tb_irq_stim_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic ra, rb, rc, rd;
   irq_stim_if #(.N_CH(6), .CNT_W(32)) ifa ();
   irq_stim_if #(.N_CH(6), .CNT_W(32)) ifb ();
   irq_stim_if #(.N_CH(6), .CNT_W(32)) ifc ();
   irq_stim_if #(.N_CH(6), .CNT_W(32)) ifd ();

   irq_stim_gen u_a (.i_clk(clk), .i_reset(ra), .bus(ifa));
   irq_stim_gen #(.LEVEL_MODE(1)) u_b (.i_clk(clk), .i_reset(rb), .bus(ifb));
   irq_stim_gen #(.FIRST_DELAY(198), .STAGGER(1), .MAX_FIRES(0), .MAX_CYCLES(200))
      u_c (.i_clk(clk), .i_reset(rc), .bus(ifc));
   irq_stim_gen #(.FIRST_DELAY(1), .STAGGER(0), .PULSE_W(1), .PERIOD(2))
      u_d (.i_clk(clk), .i_reset(rd), .bus(ifd));

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(inout int t, input int upto);
      while (t < upto) begin
         tick();
         t++;
      end
   endtask

   // Default-config schedule: rise j of channel k at enabled count D+k*S+j*(PW+PER).
   localparam int D = 100, S = 37, PW = 4, PER = 500, MF = 3, NC = 6;

   function automatic logic [5:0] m_irq(input int e);
      logic [5:0] v = '0;
      for (int k = 0; k < NC; k++)
         for (int j = 0; j < MF; j++) begin
            int r = D + k*S + j*(PW + PER);
            if (e >= r && e < r + PW) v[k] = 1'b1;
         end
      return v;
   endfunction

   function automatic int m_ft(input int e);
      int n = 0;
      for (int k = 0; k < NC; k++)
         for (int j = 0; j < MF; j++)
            if (D + k*S + j*(PW + PER) <= e) n++;
      return n;
   endfunction

   function automatic int m_last_fall();
      int f = 0;
      for (int k = 0; k < NC; k++)
         if (D + k*S + (MF-1)*(PW + PER) + PW > f) f = D + k*S + (MF-1)*(PW + PER) + PW;
      return f;
   endfunction

   typedef struct {
      int         cyc;
      logic       en;
      logic [5:0] irq;
      int         cnt;
      int         ft;
      logic       done;
   } vec_t;

   vec_t tab[13];

   initial begin
      int t;
      int e, eprev;
      logic en_v;

      tab[0]  = '{99,   1'b1, 6'h00, 99,   0,  1'b0};
      tab[1]  = '{100,  1'b1, 6'h01, 100,  1,  1'b0};
      tab[2]  = '{103,  1'b1, 6'h01, 103,  1,  1'b0};
      tab[3]  = '{104,  1'b1, 6'h00, 104,  1,  1'b0};
      tab[4]  = '{137,  1'b1, 6'h02, 137,  2,  1'b0};
      tab[5]  = '{140,  1'b1, 6'h02, 140,  2,  1'b0};
      tab[6]  = '{141,  1'b1, 6'h00, 141,  2,  1'b0};
      tab[7]  = '{174,  1'b1, 6'h04, 174,  3,  1'b0};
      tab[8]  = '{285,  1'b1, 6'h20, 285,  6,  1'b0};
      tab[9]  = '{604,  1'b1, 6'h01, 604,  7,  1'b0};
      tab[10] = '{608,  1'b1, 6'h00, 608,  7,  1'b0};
      tab[11] = '{1297, 1'b1, 6'h00, 1297, 18, 1'b0};
      tab[12] = '{1298, 1'b1, 6'h00, 1298, 18, 1'b1};

      {ra, rb, rc, rd} = 4'hf;
      ifa.en = 1'b0; ifb.en = 1'b0; ifc.en = 1'b0; ifd.en = 1'b0;
      ifa.ack = '0;  ifb.ack = '0;  ifc.ack = '0;  ifd.ack = '0;
      tick(); tick();

      chk("rst_irq", ifa.irq, 0);
      chk("rst_cnt", ifa.cycle_cnt, 0);
      chk("rst_ft", ifa.fire_total, 0);
      chk("rst_done", ifa.done, 0);
      chk("rst_timeout", ifa.timeout, 0);

      // Default timeline with en held high
      ra = 1'b0; t = 0;
      foreach (tab[i]) begin
         ifa.en = tab[i].en;
         run_to(t, tab[i].cyc);
         chk($sformatf("tab%0d_irq", i), ifa.irq, tab[i].irq);
         chk($sformatf("tab%0d_cnt", i), ifa.cycle_cnt, tab[i].cnt);
         chk($sformatf("tab%0d_ft", i), ifa.fire_total, tab[i].ft);
         chk($sformatf("tab%0d_done", i), ifa.done, tab[i].done);
      end

      // en low for 50 cycles starting after cycle 60
      ra = 1'b1; tick(); ra = 1'b0; ifa.en = 1'b1; t = 0;
      run_to(t, 60);
      ifa.en = 1'b0;
      run_to(t, 110);
      chk("enlow_cnt_frozen", ifa.cycle_cnt, 60);
      ifa.en = 1'b1;
      run_to(t, 149);
      chk("enlow_irq0_pre", ifa.irq[0], 0);
      run_to(t, 150);
      chk("enlow_irq0_rise", ifa.irq[0], 1);
      chk("enlow_cnt_at_rise", ifa.cycle_cnt, 100);

      // Reset while a pulse is active
      ra = 1'b1; tick(); ra = 1'b0; t = 0;
      run_to(t, 101);
      chk("midrst_irq0_high", ifa.irq[0], 1);
      ra = 1'b1; tick();
      chk("midrst_irq", ifa.irq, 0);
      chk("midrst_cnt", ifa.cycle_cnt, 0);
      chk("midrst_ft", ifa.fire_total, 0);
      ra = 1'b0; t = 0;
      run_to(t, 99);
      chk("midrst_irq0_pre", ifa.irq[0], 0);
      run_to(t, 100);
      chk("midrst_irq0_rise", ifa.irq[0], 1);

      // Random en/ack against the schedule model
      ra = 1'b1; tick(); ra = 1'b0;
      e = 0; eprev = 0;
      for (int c = 0; c < 2400; c++) begin
         en_v = ($urandom_range(0, 3) != 0);
         ifa.en = en_v;
         ifa.ack = 6'($urandom);
         tick();
         if (en_v) e++;
         chk("rnd_irq", ifa.irq, m_irq(e));
         chk("rnd_cnt", ifa.cycle_cnt, e);
         chk("rnd_ft", ifa.fire_total, m_ft(e));
         chk("rnd_done", ifa.done, eprev >= m_last_fall());
         eprev = e;
      end
      ra = 1'b1; ifa.ack = '0;

      // Level mode: ack handling
      rb = 1'b0; ifb.en = 1'b1; t = 0;
      run_to(t, 149);
      ifb.ack = 6'h04; tick(); t++; ifb.ack = '0;
      chk("lvl_ack_in_wait", ifb.irq[2], 0);
      run_to(t, 173);
      chk("lvl_irq2_pre", ifb.irq[2], 0);
      run_to(t, 174);
      chk("lvl_irq2_rise", ifb.irq[2], 1);
      run_to(t, 183);
      chk("lvl_irq2_held", ifb.irq[2], 1);
      ifb.ack = 6'h04; tick(); t++; ifb.ack = '0;
      chk("lvl_irq2_fall", ifb.irq[2], 0);
      chk("lvl_irq0_held", ifb.irq[0], 1);
      run_to(t, 683);
      chk("lvl_irq2_wait", ifb.irq[2], 0);
      run_to(t, 684);
      chk("lvl_irq2_rise2", ifb.irq[2], 1);
      run_to(t, 699);
      ifb.en = 1'b0; ifb.ack = 6'h01; tick(); t++; ifb.ack = '0; ifb.en = 1'b1;
      chk("lvl_ack_en0_irq0", ifb.irq[0], 0);
      chk("lvl_ack_en0_cnt", ifb.cycle_cnt, 699);
      rb = 1'b1;

      // Watchdog with pulses active at the trip edge
      rc = 1'b0; ifc.en = 1'b1; t = 0;
      run_to(t, 199);
      chk("wd_irq_pre", ifc.irq, 6'h03);
      chk("wd_ft_pre", ifc.fire_total, 2);
      chk("wd_to_pre", ifc.timeout, 0);
      run_to(t, 200);
      chk("wd_to", ifc.timeout, 1);
      chk("wd_irq", ifc.irq, 0);
      chk("wd_cnt", ifc.cycle_cnt, 200);
      chk("wd_ft", ifc.fire_total, 2);
      ifc.ack = 6'h3f;
      run_to(t, 220);
      ifc.ack = '0;
      chk("wd_cnt_stuck", ifc.cycle_cnt, 200);
      chk("wd_irq_stuck", ifc.irq, 0);
      chk("wd_to_sticky", ifc.timeout, 1);
      chk("wd_ft_stuck", ifc.fire_total, 2);
      rc = 1'b1; tick();
      chk("wd_rst_to", ifc.timeout, 0);
      chk("wd_rst_cnt", ifc.cycle_cnt, 0);

      // All channels together, single-cycle pulses
      rd = 1'b0; ifd.en = 1'b1; t = 0;
      run_to(t, 1);
      chk("all_rise_irq", ifd.irq, 6'h3f);
      chk("all_rise_ft", ifd.fire_total, 6);
      run_to(t, 2);
      chk("all_fall_irq", ifd.irq, 0);
      run_to(t, 4);
      chk("all_rise2_irq", ifd.irq, 6'h3f);
      chk("all_rise2_ft", ifd.fire_total, 12);
      run_to(t, 7);
      chk("all_rise3_ft", ifd.fire_total, 18);
      run_to(t, 8);
      chk("all_last_irq", ifd.irq, 0);
      chk("all_done_pre", ifd.done, 0);
      run_to(t, 9);
      chk("all_done", ifd.done, 1);
      run_to(t, 20);
      chk("all_ft_final", ifd.fire_total, 18);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
